polyveck_power2round_inv: RTL and testbench

Sequential inverse of the polyveck power2round split: rebuilds t = t1*2^D + t0 for every coefficient of a K=6 polynomial vector.
Used on the verify/pack side to recombine (t1, t0) into t, or with t0 = 0 to produce t1*2^D.
Takes the same flat 49152-bit vector layout: polynomial x at bits [8192x+8191 : 8192x], coefficient i at [32i+31 : 32i], signed 32-bit.
Processes LANES coefficients per cycle under a start/busy/done handshake.

---
 rtl/polyveck_power2round_inv.sv | 130 +++++++++++++
 tb/tb_polyveck_power2round_inv.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/polyveck_power2round_inv.sv
// Sequential inverse of polyveck power2round: rebuilds t = (t1 << D) + t0 for K*256 coefficients, LANES per cycle.
// Optional range checking of t1/t0 is enabled by defining POLYVECK_P2R_INV_RANGE_CHECK_EN.
module polyveck_power2round_inv #(
  parameter int K     = 6,
  parameter int D     = 13,
  parameter int LANES = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [K*256*32-1:0]    v1_in,
  input  logic [K*256*32-1:0]    v0_in,
  output logic [K*256*32-1:0]    v_out,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int DATA_W = 32;
  localparam int NCOEF  = K * 256;
  localparam int VEC_W  = NCOEF * DATA_W;
  localparam int CH     = NCOEF / LANES;
  localparam int IDX_W  = (CH > 1) ? $clog2(CH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q;
  logic [VEC_W-1:0]          v1_q, v0_q;
  logic signed [DATA_W-1:0]  res [LANES];
  logic                      last_chunk;
  logic                      accept;

  // Two's-complement wrap is intended: no saturation on overflow.
  function automatic logic signed [DATA_W-1:0] recombine(input logic signed [DATA_W-1:0] t1,
                                                         input logic signed [DATA_W-1:0] t0);
    return (t1 <<< D) + t0;
  endfunction

  assign last_chunk = (idx_q == IDX_W'(CH - 1));
  assign accept     = (state_q == IDLE) && start;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_chunk) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      res[l] = recombine(v1_q[DATA_W*(int'(idx_q)*LANES + l) +: DATA_W],
                         v0_q[DATA_W*(int'(idx_q)*LANES + l) +: DATA_W]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      v1_q    <= '0;
      v0_q    <= '0;
      v_out   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            v1_q  <= v1_in;
            v0_q  <= v0_in;
            idx_q <= '0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          for (int l = 0; l < LANES; l++) begin
            v_out[DATA_W*(int'(idx_q)*LANES + l) +: DATA_W] <= res[l];
          end
          if (last_chunk) begin
            idx_q <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: done <= 1'b0;
        default: begin
          busy <= 1'b0;
          done <= 1'b0;
        end
      endcase
    end
  end

`ifdef POLYVECK_P2R_INV_RANGE_CHECK_EN
  logic [LANES-1:0] bad;

  // Legal power2round output: t0 in -(2^(D-1)-1)..2^(D-1), t1 in 0..1023.
  function automatic logic lane_bad(input logic signed [DATA_W-1:0] t1,
                                    input logic signed [DATA_W-1:0] t0);
    return (t0 < -((2 ** (D - 1)) - 1)) || (t0 > (2 ** (D - 1))) || (t1 < 0) || (t1 > 1023);
  endfunction

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      bad[l] = lane_bad(v1_q[DATA_W*(int'(idx_q)*LANES + l) +: DATA_W],
                        v0_q[DATA_W*(int'(idx_q)*LANES + l) +: DATA_W]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (accept) begin
      err <= 1'b0;
    end else if ((state_q == RUN) && (|bad)) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_polyveck_power2round_inv.sv
// Scoreboard bench for polyveck_power2round_inv: three instances (LANES 8, 1, 32) checked against a plain-arithmetic model.
module tb_polyveck_power2round_inv;

  localparam int N  = 1536;
  localparam int VW = N * 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [2:0]     start_s;
  logic [VW-1:0]  v1_in, v0_in;
  logic [VW-1:0]  vout_s [3];
  logic [2:0]     busy_s, done_s, err_s;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    polyveck_power2round_inv #(.LANES(g == 0 ? 8 : (g == 1 ? 1 : 32))) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start_s[g]),
      .v1_in (v1_in),
      .v0_in (v0_in),
      .v_out (vout_s[g]),
      .busy  (busy_s[g]),
      .done  (done_s[g]),
      .err   (err_s[g])
    );
  end

  function automatic int lanes_of(input int i);
    return (i == 0) ? 8 : ((i == 1) ? 1 : 32);
  endfunction

  // Reference data for the next job
  int             m1 [N];
  int             m0 [N];
  int             ref_out [N];

  // Scoreboard
  logic [VW-1:0]  exp_vec [$];
  bit             exp_err [$];
  int             fifo [3][64];
  int             wr [3];
  int             rd [3];
  int             busy_cnt [3];
  int             errors = 0;
  int             checks = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  function automatic bit model_err();
    bit e = 1'b0;
`ifdef POLYVECK_P2R_INV_RANGE_CHECK_EN
    for (int j = 0; j < N; j++)
      if (m0[j] < -4095 || m0[j] > 4096 || m1[j] < 0 || m1[j] > 1023) e = 1'b1;
`endif
    return e;
  endfunction

  task automatic clear_model();
    for (int j = 0; j < N; j++) begin
      m1[j] = 0; m0[j] = 0;
    end
  endtask

  task automatic model_sum();
    for (int j = 0; j < N; j++) ref_out[j] = m1[j] * 8192 + m0[j];
  endtask

  // Software power2round of random a; expected output is a itself.
  task automatic model_roundtrip();
    int a;
    for (int j = 0; j < N; j++) begin
      a = int'($urandom_range(8380416, 0));
      m1[j] = (a + 4095) >>> 13;
      m0[j] = a - m1[j] * 8192;
      ref_out[j] = a;
    end
  endtask

  task automatic apply_inputs();
    for (int j = 0; j < N; j++) begin
      v1_in[32*j +: 32] = m1[j];
      v0_in[32*j +: 32] = m0[j];
    end
  endtask

  task automatic scramble_inputs();
    for (int j = 0; j < N; j++) begin
      v1_in[32*j +: 32] = $urandom;
      v0_in[32*j +: 32] = $urandom;
    end
  endtask

  task automatic push_job(input logic [2:0] mask);
    logic [VW-1:0] vec;
    int id;
    id = exp_vec.size();
    for (int j = 0; j < N; j++) vec[32*j +: 32] = ref_out[j];
    exp_vec.push_back(vec);
    exp_err.push_back(model_err());
    for (int i = 0; i < 3; i++) begin
      if (mask[i]) begin
        fifo[i][wr[i] % 64] = id;
        wr[i]++;
      end
    end
  endtask

  task automatic run_job(input logic [2:0] mask);
    push_job(mask);
    apply_inputs();
    start_s = mask;
    @(posedge clk);
    #1;
    start_s = 3'b000;
    scramble_inputs();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    int pend = 1;
    while (pend != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
      pend = 0;
      for (int i = 0; i < 3; i++) if (rd[i] != wr[i]) pend++;
    end
    chk("jobs still pending at timeout", pend, 0);
    @(negedge clk);
  endtask

  // Monitor: pops one expected job per done pulse and compares.
  always @(negedge clk) begin : mon
    int id, nbad, first;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        rd[i] = wr[i];
        busy_cnt[i] = 0;
      end else begin
        if (busy_s[i]) busy_cnt[i]++;
        if (done_s[i]) begin
          if (rd[i] == wr[i]) begin
            chk($sformatf("inst%0d done pulses with nothing expected", i), 1, 0);
          end else begin
            id = fifo[i][rd[i] % 64];
            rd[i]++;
            nbad = 0;
            first = -1;
            for (int j = 0; j < N; j++) begin
              if (vout_s[i][32*j +: 32] != exp_vec[id][32*j +: 32]) begin
                nbad++;
                if (first < 0) first = j;
              end
            end
            chk($sformatf("inst%0d job%0d wrong coefs (first %0d)", i, id, first), nbad, 0);
            chk($sformatf("inst%0d job%0d err", i, id), err_s[i], exp_err[id]);
            chk($sformatf("inst%0d job%0d busy cycles", i, id), busy_cnt[i], N / lanes_of(i));
          end
          busy_cnt[i] = 0;
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    start_s = 3'b000;
    v1_in   = '0;
    v0_in   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset busy", busy_s[0], 0);
    chk("reset done", done_s[0], 0);
    chk("reset err", err_s[0], 0);
    chk("reset v_out nonzero", vout_s[0] != '0, 0);

    // All-zero job
    clear_model(); model_sum();
    run_job(3'b001);
    wait_idle(400);

    // Directed slots, including both t0 extremes and max t1
    clear_model();
    m1[0] = 1; m0[1] = 4096; m1[1535] = 1023; m0[1535] = -4095;
    model_sum();
    chk("model slot1535", ref_out[1535], 8376321);
    run_job(3'b001);
    wait_idle(400);

    // Round trip on all three lane widths
    for (int r = 0; r < 2; r++) begin
      model_roundtrip();
      run_job(3'b111);
      wait_idle(2000);
    end

    // Full-range 32-bit values exercise wrap-around
    for (int j = 0; j < N; j++) begin
      m1[j] = int'($urandom); m0[j] = int'($urandom);
    end
    model_sum();
    run_job(3'b001);
    wait_idle(400);

    // start re-pulsed mid-run and in the DONE cycle must be ignored
    model_roundtrip();
    run_job(3'b001);
    repeat (49) @(negedge clk);
    scramble_inputs();
    start_s[0] = 1'b1;
    @(posedge clk);
    #1;
    start_s[0] = 1'b0;
    begin
      int n = 0;
      while (!done_s[0] && n < 400) begin
        @(negedge clk);
        n++;
      end
      chk("done seen after re-pulse", done_s[0], 1);
    end
    model_roundtrip();
    push_job(3'b001);
    scramble_inputs();
    start_s[0] = 1'b1;
    @(posedge clk);
    #1;
    apply_inputs();
    @(posedge clk);
    #1;
    start_s[0] = 1'b0;
    scramble_inputs();
    wait_idle(400);

    // Asynchronous reset mid-run
    model_roundtrip();
    run_job(3'b001);
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun reset busy", busy_s[0], 0);
    chk("midrun reset done", done_s[0], 0);
    chk("midrun reset v_out nonzero", vout_s[0] != '0, 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    model_roundtrip();
    run_job(3'b001);
    wait_idle(400);

    // Out-of-range t0: result still computed; err follows the build option
    clear_model();
    m1[700] = 2; m0[700] = 4097;
    model_sum();
    run_job(3'b001);
    wait_idle(400);
    clear_model(); model_sum();
    run_job(3'b001);
    wait_idle(400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
